// File: rtl/apb_cmd_pkg.sv
// Shared types for the APB command master: FSM states, response status and
// the sizing helper for the ACCESS timeout counter.
package apb_cmd_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETUP,
      ST_ACCESS,
      ST_RESP
   } state_e;

   typedef struct packed {
      logic err;
      logic timeout;
   } rsp_stat_t;

   // A zero TIMEOUT disables the counter, but it still needs one bit to exist.
   function automatic int tcnt_width(int timeout);
      return (timeout > 0) ? $clog2(timeout + 1) : 1;
   endfunction

endpackage

// File: rtl/apb_cmd_master_if.sv
// Command, response and APB signal bundle of the APB command master.
// The master modport is the requester side; slave is the issuer/peripheral side.
interface apb_cmd_master_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   localparam int STRB_W = DATA_W / 8;

   logic              cmd_valid_i;
   logic              cmd_ready_o;
   logic              cmd_write_i;
   logic [ADDR_W-1:0] cmd_addr_i;
   logic [DATA_W-1:0] cmd_wdata_i;
   logic [STRB_W-1:0] cmd_strb_i;
   logic [2:0]        cmd_prot_i;

   logic              rsp_valid_o;
   logic              rsp_ready_i;
   logic [DATA_W-1:0] rsp_rdata_o;
   logic              rsp_err_o;
   logic              rsp_timeout_o;

   logic [ADDR_W-1:0] apb_addr_o;
   logic              apb_sel_o;
   logic              apb_enable_o;
   logic              apb_write_o;
   logic [STRB_W-1:0] apb_strb_o;
   logic [2:0]        apb_prot_o;
   logic [DATA_W-1:0] apb_wdata_o;
   logic              apb_ready_i;
   logic [DATA_W-1:0] apb_rdata_i;
   logic              apb_slverr_i;

   modport master (
      input  cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i, cmd_strb_i, cmd_prot_i,
      input  rsp_ready_i, apb_ready_i, apb_rdata_i, apb_slverr_i,
      output cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o,
      output apb_addr_o, apb_sel_o, apb_enable_o, apb_write_o, apb_strb_o,
      output apb_prot_o, apb_wdata_o
   );

   modport slave (
      output cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i, cmd_strb_i, cmd_prot_i,
      output rsp_ready_i, apb_ready_i, apb_rdata_i, apb_slverr_i,
      input  cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o,
      input  apb_addr_o, apb_sel_o, apb_enable_o, apb_write_o, apb_strb_o,
      input  apb_prot_o, apb_wdata_o
   );

endinterface

// File: rtl/apb_cmd_master_fifo.sv
// Synchronous command FIFO; a push while full is dropped, so a full FIFO only
// accepts again in the cycle after a pop has freed an entry.
module apb_cmd_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   output logic             full,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             empty
);
   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W:0]   wr_ptr;
   logic [PTR_W:0]   rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign empty   = (wr_ptr == rd_ptr);
   // Extra pointer MSB distinguishes full from empty when the indices match.
   assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                    (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
   assign rdata   = mem[rd_ptr[PTR_W-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[PTR_W-1:0]] <= wdata;
   end

endmodule

// File: rtl/apb_cmd_master.sv
// APB4 requester: queued commands are executed one APB transfer each, with
// wait-state handling, an optional ACCESS timeout and a response channel.
module apb_cmd_master
   import apb_cmd_pkg::*;
#(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int CMD_DEPTH = 4,
   parameter int TIMEOUT   = 256
) (
   input  logic             apb_clk_i,
   input  logic             apb_resetn_i,
   apb_cmd_master_if.master bus,
   output logic             busy_o
);
   localparam int STRB_W = DATA_W / 8;
   localparam int TCNT_W = tcnt_width(TIMEOUT);
   localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   typedef struct packed {
      logic              write;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
      logic [STRB_W-1:0] strb;
      logic [2:0]        prot;
   } cmd_t;

   cmd_t              cmd_in;
   cmd_t              cmd_out;
   logic              fifo_full;
   logic              fifo_empty;
   logic              push;
   logic              pop;
   logic              rdy_en;

   state_e            state;
   state_e            state_nx;
   logic              sel_q, sel_nx;
   logic              en_q, en_nx;
   logic [TCNT_W-1:0] tcnt_q, tcnt_nx;
   logic              rsp_vld_q, rsp_vld_nx;
   logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_nx;
   rsp_stat_t         rsp_stat_q, rsp_stat_nx;

   logic [ADDR_W-1:0] addr_q;
   logic              write_q;
   logic [STRB_W-1:0] strb_q;
   logic [2:0]        prot_q;
   logic [DATA_W-1:0] wdata_q;

   assign cmd_in = '{write: bus.cmd_write_i, addr: bus.cmd_addr_i, wdata: bus.cmd_wdata_i,
                     strb: bus.cmd_strb_i, prot: bus.cmd_prot_i};
   assign push   = bus.cmd_valid_i && bus.cmd_ready_o;

   apb_cmd_fifo #(
      .WIDTH ($bits(cmd_t)),
      .DEPTH (CMD_DEPTH)
   ) u_fifo (
      .clk   (apb_clk_i),
      .rst_n (apb_resetn_i),
      .push  (push),
      .wdata (cmd_in),
      .full  (fifo_full),
      .pop   (pop),
      .rdata (cmd_out),
      .empty (fifo_empty)
   );

   // Holds cmd_ready_o low until the first clock edge after reset release.
   always_ff @(posedge apb_clk_i or negedge apb_resetn_i) begin
      if (!apb_resetn_i) rdy_en <= 1'b0;
      else               rdy_en <= 1'b1;
   end

   always_ff @(posedge apb_clk_i or negedge apb_resetn_i) begin
      if (!apb_resetn_i) state <= ST_IDLE;
      else               state <= state_nx;
   end

   always_comb begin
      state_nx     = state;
      pop          = 1'b0;
      sel_nx       = sel_q;
      en_nx        = en_q;
      tcnt_nx      = tcnt_q;
      rsp_vld_nx   = rsp_vld_q;
      rsp_rdata_nx = rsp_rdata_q;
      rsp_stat_nx  = rsp_stat_q;
      unique case (state)
         ST_IDLE: begin
            if (!fifo_empty) begin
               pop      = 1'b1;
               sel_nx   = 1'b1;
               state_nx = ST_SETUP;
            end
         end
         ST_SETUP: begin
            en_nx    = 1'b1;
            state_nx = ST_ACCESS;
         end
         ST_ACCESS: begin
            if (bus.apb_ready_i) begin
               sel_nx       = 1'b0;
               en_nx        = 1'b0;
               rsp_vld_nx   = 1'b1;
               rsp_rdata_nx = write_q ? '0 : bus.apb_rdata_i;
               rsp_stat_nx  = '{err: bus.apb_slverr_i, timeout: 1'b0};
               state_nx     = ST_RESP;
            end else if ((TIMEOUT != 0) && (tcnt_q == TCNT_LAST)) begin
               sel_nx       = 1'b0;
               en_nx        = 1'b0;
               rsp_vld_nx   = 1'b1;
               rsp_rdata_nx = '0;
               rsp_stat_nx  = '{err: 1'b1, timeout: 1'b1};
               state_nx     = ST_RESP;
            end else begin
               tcnt_nx = tcnt_q + 1'b1;
            end
         end
         ST_RESP: begin
            if (bus.rsp_ready_i) begin
               rsp_vld_nx = 1'b0;
               if (!fifo_empty) begin
                  pop      = 1'b1;
                  sel_nx   = 1'b1;
                  state_nx = ST_SETUP;
               end else begin
                  state_nx = ST_IDLE;
               end
            end
         end
         default: state_nx = ST_IDLE;
      endcase
      if (pop) tcnt_nx = '0;
   end

   always_ff @(posedge apb_clk_i or negedge apb_resetn_i) begin
      if (!apb_resetn_i) begin
         sel_q       <= 1'b0;
         en_q        <= 1'b0;
         tcnt_q      <= '0;
         rsp_vld_q   <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_stat_q  <= '0;
         addr_q      <= '0;
         write_q     <= 1'b0;
         strb_q      <= '0;
         prot_q      <= '0;
         wdata_q     <= '0;
      end else begin
         sel_q       <= sel_nx;
         en_q        <= en_nx;
         tcnt_q      <= tcnt_nx;
         rsp_vld_q   <= rsp_vld_nx;
         rsp_rdata_q <= rsp_rdata_nx;
         rsp_stat_q  <= rsp_stat_nx;
         // Transfer attributes only change on a pop, so they stay stable through ACCESS.
         if (pop) begin
            addr_q  <= cmd_out.addr;
            write_q <= cmd_out.write;
            strb_q  <= cmd_out.write ? cmd_out.strb : '0;
            prot_q  <= cmd_out.prot;
            wdata_q <= cmd_out.wdata;
         end
      end
   end

   assign bus.cmd_ready_o   = rdy_en && !fifo_full;
   assign bus.rsp_valid_o   = rsp_vld_q;
   assign bus.rsp_rdata_o   = rsp_rdata_q;
   assign bus.rsp_err_o     = rsp_stat_q.err;
   assign bus.rsp_timeout_o = rsp_stat_q.timeout;
   assign bus.apb_addr_o    = addr_q;
   assign bus.apb_sel_o     = sel_q;
   assign bus.apb_enable_o  = en_q;
   assign bus.apb_write_o   = write_q;
   assign bus.apb_strb_o    = strb_q;
   assign bus.apb_prot_o    = prot_q;
   assign bus.apb_wdata_o   = wdata_q;
   assign busy_o            = !fifo_empty || (state != ST_IDLE);

endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed bench for apb_cmd_master: single writes/reads, wait states, slave
// error, timeout, queue back-pressure with drain order, and reset mid-transfer.
module tb_apb_cmd_master;
   localparam int ADDR_W    = 32;
   localparam int DATA_W    = 32;
   localparam int CMD_DEPTH = 4;
   localparam int TIMEOUT   = 8;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic busy;
   int   n_vec = 0;
   int   n_err = 0;

   apb_cmd_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   apb_cmd_master #(
      .ADDR_W    (ADDR_W),
      .DATA_W    (DATA_W),
      .CMD_DEPTH (CMD_DEPTH),
      .TIMEOUT   (TIMEOUT)
   ) dut (
      .apb_clk_i    (clk),
      .apb_resetn_i (rst_n),
      .bus          (bus),
      .busy_o       (busy)
   );

   always #5 clk = ~clk;

   task automatic idle_inputs();
      bus.cmd_valid_i  = 1'b0;
      bus.cmd_write_i  = 1'b0;
      bus.cmd_addr_i   = '0;
      bus.cmd_wdata_i  = '0;
      bus.cmd_strb_i   = '0;
      bus.cmd_prot_i   = '0;
      bus.rsp_ready_i  = 1'b0;
      bus.apb_ready_i  = 1'b0;
      bus.apb_rdata_i  = '0;
      bus.apb_slverr_i = 1'b0;
   endtask

   task automatic drive_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] strb, input logic [2:0] prot);
      bus.cmd_valid_i = 1'b1;
      bus.cmd_write_i = wr;
      bus.cmd_addr_i  = addr;
      bus.cmd_wdata_i = wdata;
      bus.cmd_strb_i  = strb;
      bus.cmd_prot_i  = prot;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle_inputs();
      repeat (2) @(negedge clk);
      n_vec++; if (bus.cmd_ready_o !== 1'b0) begin n_err++; $display("FAIL rst_cmd_ready: got %b want 0", bus.cmd_ready_o); end
      n_vec++; if ({bus.apb_sel_o, bus.apb_enable_o} !== 2'b00) begin n_err++; $display("FAIL rst_sel_en: got %b want 00", {bus.apb_sel_o, bus.apb_enable_o}); end
      n_vec++; if (bus.rsp_valid_o !== 1'b0) begin n_err++; $display("FAIL rst_rsp_valid: got %b want 0", bus.rsp_valid_o); end
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
      n_vec++; if (bus.apb_addr_o !== 32'h0) begin n_err++; $display("FAIL rst_addr: got %h want 0", bus.apb_addr_o); end
      rst_n = 1'b1;
      #1;
      n_vec++; if (bus.cmd_ready_o !== 1'b0) begin n_err++; $display("FAIL rst_rel_ready_early: got %b want 0", bus.cmd_ready_o); end
      @(negedge clk);
      n_vec++; if (bus.cmd_ready_o !== 1'b1) begin n_err++; $display("FAIL rst_rel_ready: got %b want 1", bus.cmd_ready_o); end
   endtask

   task automatic test_write();
      @(negedge clk);
      bus.apb_ready_i = 1'b1;
      bus.apb_rdata_i = 32'h55AA55AA;
      drive_cmd(1'b1, 32'h100, 32'hDEADBEEF, 4'hF, 3'b010);
      @(negedge clk);
      bus.cmd_valid_i = 1'b0;
      n_vec++; if ({busy, bus.apb_sel_o} !== 2'b10) begin n_err++; $display("FAIL wr_queued: busy/sel got %b want 10", {busy, bus.apb_sel_o}); end
      @(negedge clk);
      n_vec++; if ({bus.apb_sel_o, bus.apb_enable_o} !== 2'b10) begin n_err++; $display("FAIL wr_setup: sel/en got %b want 10", {bus.apb_sel_o, bus.apb_enable_o}); end
      n_vec++; if (bus.apb_addr_o !== 32'h100) begin n_err++; $display("FAIL wr_addr: got %h want 00000100", bus.apb_addr_o); end
      n_vec++; if (bus.apb_wdata_o !== 32'hDEADBEEF) begin n_err++; $display("FAIL wr_wdata: got %h want deadbeef", bus.apb_wdata_o); end
      n_vec++; if ({bus.apb_write_o, bus.apb_strb_o, bus.apb_prot_o} !== {1'b1, 4'hF, 3'b010}) begin n_err++; $display("FAIL wr_ctl: write/strb/prot got %b want 11111010", {bus.apb_write_o, bus.apb_strb_o, bus.apb_prot_o}); end
      @(negedge clk);
      n_vec++; if ({bus.apb_sel_o, bus.apb_enable_o, bus.rsp_valid_o} !== 3'b110) begin n_err++; $display("FAIL wr_access: sel/en/rsp got %b want 110", {bus.apb_sel_o, bus.apb_enable_o, bus.rsp_valid_o}); end
      n_vec++; if (bus.apb_wdata_o !== 32'hDEADBEEF) begin n_err++; $display("FAIL wr_wdata_hold: got %h want deadbeef", bus.apb_wdata_o); end
      @(negedge clk);
      n_vec++; if ({bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_timeout_o, bus.apb_sel_o} !== 4'b1000) begin n_err++; $display("FAIL wr_resp: valid/err/to/sel got %b want 1000", {bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_timeout_o, bus.apb_sel_o}); end
      n_vec++; if (bus.rsp_rdata_o !== 32'h0) begin n_err++; $display("FAIL wr_rsp_rdata: got %h want 0", bus.rsp_rdata_o); end
      @(negedge clk);
      n_vec++; if (bus.rsp_valid_o !== 1'b1) begin n_err++; $display("FAIL wr_rsp_hold: got %b want 1", bus.rsp_valid_o); end
      bus.rsp_ready_i = 1'b1;
      @(negedge clk);
      bus.rsp_ready_i = 1'b0;
      n_vec++; if ({bus.rsp_valid_o, busy} !== 2'b00) begin n_err++; $display("FAIL wr_done: valid/busy got %b want 00", {bus.rsp_valid_o, busy}); end
   endtask

   task automatic test_read_wait();
      @(negedge clk);
      bus.apb_ready_i = 1'b0;
      bus.apb_rdata_i = 32'h12345678;
      drive_cmd(1'b0, 32'h104, 32'hFFFFFFFF, 4'hF, 3'b000);
      @(negedge clk);
      bus.cmd_valid_i = 1'b0;
      @(negedge clk);
      n_vec++; if ({bus.apb_sel_o, bus.apb_enable_o, bus.apb_write_o} !== 3'b100) begin n_err++; $display("FAIL rd_setup: sel/en/write got %b want 100", {bus.apb_sel_o, bus.apb_enable_o, bus.apb_write_o}); end
      n_vec++; if ({bus.apb_addr_o, bus.apb_strb_o} !== {32'h104, 4'h0}) begin n_err++; $display("FAIL rd_setup_addr_strb: got %h want 1040", {bus.apb_addr_o, bus.apb_strb_o}); end
      for (int w = 0; w < 3; w++) begin
         @(negedge clk);
         n_vec++; if ({bus.apb_sel_o, bus.apb_enable_o, bus.apb_strb_o, bus.rsp_valid_o} !== 7'b1100000) begin n_err++; $display("FAIL rd_access_%0d: sel/en/strb/rsp got %b want 1100000", w, {bus.apb_sel_o, bus.apb_enable_o, bus.apb_strb_o, bus.rsp_valid_o}); end
      end
      bus.apb_ready_i = 1'b1;
      @(negedge clk);
      n_vec++; if ({bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_timeout_o} !== 3'b100) begin n_err++; $display("FAIL rd_resp: valid/err/to got %b want 100", {bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_timeout_o}); end
      n_vec++; if (bus.rsp_rdata_o !== 32'h12345678) begin n_err++; $display("FAIL rd_rdata: got %h want 12345678", bus.rsp_rdata_o); end
      bus.rsp_ready_i = 1'b1;
      @(negedge clk);
      bus.rsp_ready_i = 1'b0;
      n_vec++; if (bus.rsp_valid_o !== 1'b0) begin n_err++; $display("FAIL rd_done: got %b want 0", bus.rsp_valid_o); end
   endtask

   task automatic test_slverr();
      @(negedge clk);
      bus.apb_ready_i  = 1'b1;
      bus.apb_slverr_i = 1'b1;
      drive_cmd(1'b1, 32'h108, 32'h0BADF00D, 4'h3, 3'b001);
      @(negedge clk);
      bus.cmd_valid_i = 1'b0;
      repeat (3) @(negedge clk);
      n_vec++; if ({bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_timeout_o} !== 3'b110) begin n_err++; $display("FAIL slverr_resp: valid/err/to got %b want 110", {bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_timeout_o}); end
      bus.rsp_ready_i  = 1'b1;
      bus.apb_slverr_i = 1'b0;
      @(negedge clk);
      bus.rsp_ready_i = 1'b0;
   endtask

   task automatic test_timeout();
      @(negedge clk);
      bus.apb_ready_i = 1'b0;
      bus.apb_rdata_i = 32'hCAFEF00D;
      drive_cmd(1'b0, 32'h200, 32'h0, 4'h0, 3'b000);
      @(negedge clk);
      bus.cmd_valid_i = 1'b0;
      @(negedge clk);
      for (int c = 0; c < TIMEOUT; c++) begin
         @(negedge clk);
         n_vec++; if ({bus.apb_sel_o, bus.apb_enable_o, bus.rsp_valid_o} !== 3'b110) begin n_err++; $display("FAIL to_access_%0d: sel/en/rsp got %b want 110", c, {bus.apb_sel_o, bus.apb_enable_o, bus.rsp_valid_o}); end
      end
      @(negedge clk);
      n_vec++; if ({bus.apb_sel_o, bus.apb_enable_o} !== 2'b00) begin n_err++; $display("FAIL to_sel_drop: sel/en got %b want 00", {bus.apb_sel_o, bus.apb_enable_o}); end
      n_vec++; if ({bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_timeout_o} !== 3'b111) begin n_err++; $display("FAIL to_resp: valid/err/to got %b want 111", {bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_timeout_o}); end
      n_vec++; if (bus.rsp_rdata_o !== 32'h0) begin n_err++; $display("FAIL to_rdata: got %h want 0", bus.rsp_rdata_o); end
      bus.rsp_ready_i = 1'b1;
      bus.apb_ready_i = 1'b1;
      @(negedge clk);
      bus.rsp_ready_i = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp_addr;
      logic [31:0] exp_wdata;
      int          waited;
      @(negedge clk);
      bus.apb_ready_i = 1'b1;
      bus.rsp_ready_i = 1'b0;
      for (int i = 0; i < 5; i++) begin
         drive_cmd(1'b1, 32'h300 + 32'(4 * i), 32'h11110000 + 32'(i), 4'hF, 3'b000);
         waited = 0;
         while (bus.cmd_ready_o !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
         end
         if (waited >= 20) begin
            n_vec++; n_err++;
            $display("FAIL b2b_push_%0d: cmd_ready stuck at %b want 1", i, bus.cmd_ready_o);
         end
         @(negedge clk);
      end
      bus.cmd_valid_i = 1'b0;
      n_vec++; if (bus.cmd_ready_o !== 1'b0) begin n_err++; $display("FAIL b2b_full: cmd_ready got %b want 0", bus.cmd_ready_o); end
      n_vec++; if ({bus.rsp_valid_o, busy} !== 2'b11) begin n_err++; $display("FAIL b2b_stall: valid/busy got %b want 11", {bus.rsp_valid_o, busy}); end
      bus.rsp_ready_i = 1'b1;
      for (int k = 1; k < 5; k++) begin
         exp_addr  = 32'h300 + 32'(4 * k);
         exp_wdata = 32'h11110000 + 32'(k);
         @(negedge clk);
         n_vec++; if ({bus.apb_sel_o, bus.apb_enable_o, bus.rsp_valid_o} !== 3'b100) begin n_err++; $display("FAIL b2b_setup_%0d: sel/en/rsp got %b want 100", k, {bus.apb_sel_o, bus.apb_enable_o, bus.rsp_valid_o}); end
         n_vec++; if ({bus.apb_addr_o, bus.apb_wdata_o} !== {exp_addr, exp_wdata}) begin n_err++; $display("FAIL b2b_order_%0d: addr/wdata got %h want %h", k, {bus.apb_addr_o, bus.apb_wdata_o}, {exp_addr, exp_wdata}); end
         if (k == 1) begin
            n_vec++; if (bus.cmd_ready_o !== 1'b1) begin n_err++; $display("FAIL b2b_freed: cmd_ready got %b want 1", bus.cmd_ready_o); end
         end
         repeat (2) @(negedge clk);
         n_vec++; if ({bus.rsp_valid_o, bus.rsp_err_o} !== 2'b10) begin n_err++; $display("FAIL b2b_resp_%0d: valid/err got %b want 10", k, {bus.rsp_valid_o, bus.rsp_err_o}); end
      end
      @(negedge clk);
      bus.rsp_ready_i = 1'b0;
      n_vec++; if ({bus.rsp_valid_o, busy, bus.apb_sel_o} !== 3'b000) begin n_err++; $display("FAIL b2b_drained: valid/busy/sel got %b want 000", {bus.rsp_valid_o, busy, bus.apb_sel_o}); end
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      bus.apb_ready_i = 1'b0;
      drive_cmd(1'b0, 32'h400, 32'h0, 4'h0, 3'b000);
      @(negedge clk);
      bus.cmd_valid_i = 1'b0;
      repeat (2) @(negedge clk);
      n_vec++; if ({bus.apb_sel_o, bus.apb_enable_o} !== 2'b11) begin n_err++; $display("FAIL rm_access: sel/en got %b want 11", {bus.apb_sel_o, bus.apb_enable_o}); end
      rst_n = 1'b0;
      #1;
      n_vec++; if ({bus.apb_sel_o, bus.apb_enable_o, busy, bus.cmd_ready_o} !== 4'b0000) begin n_err++; $display("FAIL rm_immediate: sel/en/busy/ready got %b want 0000", {bus.apb_sel_o, bus.apb_enable_o, busy, bus.cmd_ready_o}); end
      @(negedge clk);
      rst_n = 1'b1;
      bus.apb_ready_i = 1'b1;
      bus.rsp_ready_i = 1'b1;
      repeat (4) @(negedge clk);
      n_vec++; if ({bus.rsp_valid_o, busy, bus.apb_sel_o} !== 3'b000) begin n_err++; $display("FAIL rm_no_resp: valid/busy/sel got %b want 000", {bus.rsp_valid_o, busy, bus.apb_sel_o}); end
      n_vec++; if (bus.cmd_ready_o !== 1'b1) begin n_err++; $display("FAIL rm_ready: got %b want 1", bus.cmd_ready_o); end
      bus.rsp_ready_i = 1'b0;
   endtask

   initial begin
      test_reset();
      test_write();
      test_read_wait();
      test_slverr();
      test_timeout();
      test_back_to_back();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
